timer_arbiter: RTL

Shares one down-counting interval timer among N requesters under round-robin arbitration. A requester raises its request with a duration. The block grants the timer to one requester, loads the duration and counts it down. It then pulses a one-hot done to the owner and releases the timer. It sits between the control FSMs that need timed waits and the single counter resource they share.

---
 rtl/timer_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sharing one down-counting interval timer among N requesters
module timer_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dur,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  ptr, ptr_nx;
  logic [N-1:0]   gnt_nx, done_nx;
  logic [W-1:0]   count_nx;
  logic           found;
  logic [PW-1:0]  win;
  logic [PW-1:0]  idx;
  logic [N*W-1:0] dur_sel;

  // ptr holds the last winner (and current owner), so the search starts just above it
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign dur_sel = dur >> (int'(win) * W);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    done_nx  = '0;
    count_nx = count;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        gnt_nx   = '0;
        count_nx = '0;
        if (found) begin
          gnt_nx[win] = 1'b1;
          count_nx    = dur_sel[W-1:0];
          ptr_nx      = win;
          state_nx    = RUN;
        end
      end
      RUN: begin
        if (!req[ptr]) begin
          gnt_nx   = '0;
          count_nx = '0;
          state_nx = IDLE;
        end else if (count != '0) begin
          count_nx = count - W'(1);
        end else begin
          done_nx[ptr] = 1'b1;
          gnt_nx       = '0;
          state_nx     = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        gnt_nx   = '0;
        count_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      ptr   <= PW'(N - 1);
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      done  <= done_nx;
      count <= count_nx;
      ptr   <= ptr_nx;
    end
  end

  assign busy = (state == RUN) || (state == DONE);

endmodule
